// File: rtl/cpu_mem_responder.sv
// 6502 bus-side memory responder: byte RAM window with RDY wait states and registered outputs.
// Optional write protection of the upper half of the window is enabled by MEM_RESP_WPROT_EN.
module cpu_mem_responder #(
   parameter int          MEM_AW      = 10,
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic        phi2,
   input  logic        rst,
   input  logic        cyc,
   input  logic [15:0] addr,
   input  logic        rw,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        rdy,
   output logic        wp_err
);

   localparam int         DEPTH   = 1 << MEM_AW;
   localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [MEM_AW-1:0]   a_q, a_d;
   logic                rw_q, rw_d;
   logic [7:0]          wd_q, wd_d;
   logic [7:0]          data_out_q, data_out_d;
   logic                data_oe_q, data_oe_d;
   logic                rdy_q, rdy_d;
   logic                wp_err_d;
   logic                hit;
   logic                wp_block;
   logic                mem_we;

   logic [7:0] mem [0:DEPTH-1];

   assign hit = cyc & (addr[15:MEM_AW] == BASE_ADDR[15:MEM_AW]);

`ifdef MEM_RESP_WPROT_EN
   logic wp_err_q;
   assign wp_block = a_q[MEM_AW-1];
   assign wp_err   = wp_err_q;
`else
   assign wp_block = 1'b0;
   assign wp_err   = 1'b0;
`endif

   // cnt holds the stall cycles still owed; WAIT always spends one extra
   // cycle with rdy high before RESP, so RESP lands WAIT_STATES+1 edges after capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      rw_d       = rw_q;
      wd_d       = wd_q;
      data_out_d = data_out_q;
      data_oe_d  = 1'b0;
      rdy_d      = rdy_q;
      wp_err_d   = 1'b0;
      mem_we     = 1'b0;
      case (state_q)
         S_IDLE, S_RESP: begin
            if (hit) begin
               a_d     = addr[MEM_AW-1:0];
               rw_d    = rw;
               wd_d    = data_in;
               state_d = S_WAIT;
               cnt_d   = WS_INIT;
               rdy_d   = (WAIT_STATES == 0);
            end else begin
               state_d = S_IDLE;
               rdy_d   = 1'b1;
            end
         end
         S_WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
               rdy_d = (cnt_q == 3'd1);
            end else begin
               state_d = S_RESP;
               rdy_d   = 1'b1;
               if (rw_q) begin
                  data_out_d = mem[a_q];
                  data_oe_d  = 1'b1;
               end else if (wp_block) begin
                  wp_err_d = 1'b1;
               end else begin
                  mem_we = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge phi2) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         a_q        <= '0;
         rw_q       <= 1'b1;
         wd_q       <= 8'h00;
         data_out_q <= 8'h00;
         data_oe_q  <= 1'b0;
         rdy_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         rw_q       <= rw_d;
         wd_q       <= wd_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         rdy_q      <= rdy_d;
      end
   end

`ifdef MEM_RESP_WPROT_EN
   always_ff @(posedge phi2) begin
      if (rst) wp_err_q <= 1'b0;
      else     wp_err_q <= wp_err_d;
   end
`else
   logic unused_wp;
   assign unused_wp = wp_err_d;
`endif

   // RAM is not reset; a commit coinciding with rst is dropped.
   always_ff @(posedge phi2) begin
      if (!rst && mem_we) mem[a_q] <= wd_q;
   end

   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;
   assign rdy      = rdy_q;

endmodule
